// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use interlock,
// taken-branch flush and variable-latency data-memory stalls with timeout.
module pipe_hazard_ctrl #(
  parameter int DM_TIMEOUT  = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             ID_Rs,
  input  logic [4:0]             ID_Rt,
  input  logic                   ID_UsesRs,
  input  logic                   ID_UsesRt,
  input  logic                   EX_MemRead,
  input  logic                   EX_RfWr,
  input  logic [4:0]             EX_Rw,
  input  logic                   EX_BranchTaken,
  input  logic                   MEM_DmReq,
  input  logic                   DmReady,
  output logic                   PcWr,
  output logic                   IfIdWr,
  output logic                   IfIdFlush,
  output logic                   IdExWr,
  output logic                   IdExFlush,
  output logic                   ExMemWr,
  output logic                   MemWbBubble,
  output logic                   DmErr,
  output logic [STALL_CNT_W-1:0] StallCnt
);

  typedef enum logic {RUN, DM_WAIT} state_t;

  localparam logic [7:0] WCNT_LAST = 8'(DM_TIMEOUT - 1);

  state_t                 stateReg, stateNext;
  logic [7:0]             wCntReg, wCntNext;
  logic                   dmErrReg, dmErrNext;
  logic [STALL_CNT_W-1:0] stallCntReg;
  logic                   memStall, loadUse, freeze, keepBubble;

  assign memStall = MEM_DmReq & ~DmReady;
  assign loadUse  = EX_MemRead & EX_RfWr & (EX_Rw != 5'd0) &
                    ((ID_UsesRs & (ID_Rs == EX_Rw)) | (ID_UsesRt & (ID_Rt == EX_Rw)));

  always_comb begin
    stateNext  = stateReg;
    wCntNext   = wCntReg;
    dmErrNext  = dmErrReg;
    freeze     = 1'b0;
    keepBubble = 1'b0;
    case (stateReg)
      RUN: begin
        if (memStall) begin
          freeze    = 1'b1;
          stateNext = DM_WAIT;
          wCntNext  = 8'd1;
        end
      end
      DM_WAIT: begin
        // Only DmReady releases the wait; a dropped request just runs into the timeout.
        if (DmReady) begin
          stateNext = RUN;
        end else if (wCntReg == WCNT_LAST) begin
          keepBubble = 1'b1;
          dmErrNext  = 1'b1;
          stateNext  = RUN;
        end else begin
          freeze   = 1'b1;
          wCntNext = wCntReg + 8'd1;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    PcWr        = 1'b1;
    IfIdWr      = 1'b1;
    IfIdFlush   = 1'b0;
    IdExWr      = 1'b1;
    IdExFlush   = 1'b0;
    ExMemWr     = 1'b1;
    MemWbBubble = 1'b0;
    if (rst) begin
      PcWr        = 1'b0;
      IfIdWr      = 1'b0;
      IfIdFlush   = 1'b1;
      IdExWr      = 1'b0;
      IdExFlush   = 1'b1;
      ExMemWr     = 1'b0;
      MemWbBubble = 1'b1;
    end else if (freeze) begin
      PcWr        = 1'b0;
      IfIdWr      = 1'b0;
      IdExWr      = 1'b0;
      ExMemWr     = 1'b0;
      MemWbBubble = 1'b1;
    end else begin
      MemWbBubble = keepBubble;
      // A taken branch flushes the ID instruction, so its load-use hazard is moot.
      if (EX_BranchTaken) begin
        IfIdFlush = 1'b1;
        IdExFlush = 1'b1;
      end else if (loadUse) begin
        PcWr      = 1'b0;
        IfIdWr    = 1'b0;
        IdExFlush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= RUN;
      wCntReg     <= 8'd0;
      dmErrReg    <= 1'b0;
      stallCntReg <= '0;
    end else begin
      stateReg <= stateNext;
      wCntReg  <= wCntNext;
      dmErrReg <= dmErrNext;
      if (!PcWr && (stallCntReg != {STALL_CNT_W{1'b1}}))
        stallCntReg <= stallCntReg + 1'b1;
    end
  end

  assign DmErr    = dmErrReg;
  assign StallCnt = stallCntReg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// stimulus, all checked against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int TO = 16;

  logic clk, rst;
  logic [4:0] ID_Rs, ID_Rt, EX_Rw;
  logic ID_UsesRs, ID_UsesRt, EX_MemRead, EX_RfWr, EX_BranchTaken, MEM_DmReq, DmReady;
  logic PcWr, IfIdWr, IfIdFlush, IdExWr, IdExFlush, ExMemWr, MemWbBubble, DmErr;
  logic [15:0] StallCnt;
  logic sPcWr, sIfIdWr, sIfIdFlush, sIdExWr, sIdExFlush, sExMemWr, sMemWbBubble, sDmErr;
  logic [3:0] sStallCnt;

  pipe_hazard_ctrl #(.DM_TIMEOUT(TO), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs),
    .ID_UsesRt(ID_UsesRt), .EX_MemRead(EX_MemRead), .EX_RfWr(EX_RfWr), .EX_Rw(EX_Rw),
    .EX_BranchTaken(EX_BranchTaken), .MEM_DmReq(MEM_DmReq), .DmReady(DmReady),
    .PcWr(PcWr), .IfIdWr(IfIdWr), .IfIdFlush(IfIdFlush), .IdExWr(IdExWr),
    .IdExFlush(IdExFlush), .ExMemWr(ExMemWr), .MemWbBubble(MemWbBubble),
    .DmErr(DmErr), .StallCnt(StallCnt));

  pipe_hazard_ctrl #(.DM_TIMEOUT(TO), .STALL_CNT_W(4)) dutSat (
    .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs),
    .ID_UsesRt(ID_UsesRt), .EX_MemRead(EX_MemRead), .EX_RfWr(EX_RfWr), .EX_Rw(EX_Rw),
    .EX_BranchTaken(EX_BranchTaken), .MEM_DmReq(MEM_DmReq), .DmReady(DmReady),
    .PcWr(sPcWr), .IfIdWr(sIfIdWr), .IfIdFlush(sIfIdFlush), .IdExWr(sIdExWr),
    .IdExFlush(sIdExFlush), .ExMemWr(sExMemWr), .MemWbBubble(sMemWbBubble),
    .DmErr(sDmErr), .StallCnt(sStallCnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector order: PcWr IfIdWr IfIdFlush IdExWr IdExFlush ExMemWr MemWbBubble
  logic [6:0]  obsCtl, obsCtlSat;
  logic [35:0] obsAll;
  assign obsCtl    = {PcWr, IfIdWr, IfIdFlush, IdExWr, IdExFlush, ExMemWr, MemWbBubble};
  assign obsCtlSat = {sPcWr, sIfIdWr, sIfIdFlush, sIdExWr, sIdExFlush, sExMemWr, sMemWbBubble};
  assign obsAll    = {obsCtl, DmErr, StallCnt, obsCtlSat, sDmErr, sStallCnt};

  int checks = 0;
  int failures = 0;

  // Model: waiting on memory, how many wait cycles elapsed, sticky error, stall counts.
  bit   mWait = 0;
  int   mK = 0;
  bit   mErr = 0;
  int   mCnt = 0;
  int   mCntSat = 0;
  logic [6:0] expCtl;

  function automatic logic [6:0] hazardEval();
    bit lu;
    lu = EX_MemRead && EX_RfWr && (EX_Rw != 0) &&
         ((ID_UsesRs && ID_Rs == EX_Rw) || (ID_UsesRt && ID_Rt == EX_Rw));
    if (EX_BranchTaken) return 7'b1111110;
    if (lu)             return 7'b0001110;
    return 7'b1101010;
  endfunction

  function automatic logic [35:0] expAll();
    return {expCtl, mErr, 16'(mCnt), expCtl, mErr, 4'(mCntSat)};
  endfunction

  task automatic settle();
    @(negedge clk);
    if (rst)                          expCtl = 7'b0010101;
    else if (!mWait)                  expCtl = (MEM_DmReq && !DmReady) ? 7'b0000001 : hazardEval();
    else if (DmReady)                 expCtl = hazardEval();
    else if (mK == TO - 1)            expCtl = hazardEval() | 7'b0000001;
    else                              expCtl = 7'b0000001;
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      mWait = 0; mK = 0; mErr = 0; mCnt = 0; mCntSat = 0;
    end else begin
      if (!expCtl[6]) begin
        if (mCnt < 65535) mCnt++;
        if (mCntSat < 15) mCntSat++;
      end
      if (!mWait) begin
        if (MEM_DmReq && !DmReady) begin mWait = 1; mK = 1; end
      end else if (DmReady) mWait = 0;
      else if (mK == TO - 1) begin mWait = 0; mErr = 1; end
      else mK++;
    end
    #1;
  endtask

  task automatic clearIn();
    ID_Rs = 0; ID_Rt = 0; ID_UsesRs = 0; ID_UsesRt = 0; EX_MemRead = 0; EX_RfWr = 0;
    EX_Rw = 0; EX_BranchTaken = 0; MEM_DmReq = 0; DmReady = 0;
  endtask

  task automatic pulseRst(input int n);
    clearIn();
    rst = 1;
    for (int i = 0; i < n; i++) begin settle(); advance(); end
    rst = 0;
  endtask

  task automatic test_loaduse();
    pulseRst(1);
    EX_MemRead = 1; EX_RfWr = 1; EX_Rw = 8; ID_Rt = 8; ID_UsesRt = 1;
    ID_Rs = 5'($urandom_range(9, 31)); ID_UsesRs = 1;
    settle();
    checks++; if (obsAll !== expAll()) begin failures++; $display("FAIL loaduse_model got=%h exp=%h", obsAll, expAll()); end
    checks++; if ({PcWr, IfIdWr, IdExFlush, IdExWr} !== 4'b0011) begin failures++; $display("FAIL loaduse_stall got=%b exp=0011", {PcWr, IfIdWr, IdExFlush, IdExWr}); end
    advance();
    EX_MemRead = 0;
    settle();
    checks++; if (obsAll !== expAll()) begin failures++; $display("FAIL loaduse_after_model got=%h exp=%h", obsAll, expAll()); end
    checks++; if (StallCnt !== 16'd1) begin failures++; $display("FAIL loaduse_cnt got=%0d exp=1", StallCnt); end
    advance();
    for (int k = 0; k < 2; k++) begin
      EX_MemRead = 1;
      if (k == 0) begin EX_Rw = 0; ID_Rt = 0; ID_UsesRt = 1; end
      else begin EX_Rw = 8; ID_Rt = 8; ID_UsesRt = 0; end
      settle();
      checks++; if (obsAll !== expAll()) begin failures++; $display("FAIL loaduse_nostall%0d_model got=%h exp=%h", k, obsAll, expAll()); end
      checks++; if (PcWr !== 1'b1) begin failures++; $display("FAIL loaduse_nostall%0d got PcWr=%b exp=1", k, PcWr); end
      advance();
    end
  endtask

  task automatic test_branch_loaduse();
    int r;
    pulseRst(1);
    r = $urandom_range(1, 31);
    EX_MemRead = 1; EX_RfWr = 1; EX_Rw = 5'(r); ID_Rs = 5'(r); ID_UsesRs = 1; EX_BranchTaken = 1;
    settle();
    checks++; if (obsAll !== expAll()) begin failures++; $display("FAIL branch_lu_model got=%h exp=%h", obsAll, expAll()); end
    checks++; if ({PcWr, IfIdFlush, IdExFlush, ExMemWr} !== 4'b1111) begin failures++; $display("FAIL branch_lu got=%b exp=1111", {PcWr, IfIdFlush, IdExFlush, ExMemWr}); end
    advance();
  endtask

  task automatic test_slow_mem();
    int frozen = 0;
    pulseRst(1);
    MEM_DmReq = 1; EX_BranchTaken = 1;
    for (int i = 0; i <= 4; i++) begin
      DmReady = (i == 4);
      settle();
      checks++; if (obsAll !== expAll()) begin failures++; $display("FAIL slow_mem_model c%0d got=%h exp=%h", i, obsAll, expAll()); end
      if (PcWr === 1'b0 && MemWbBubble === 1'b1) frozen++;
      if (i == 4) begin
        checks++; if ({MemWbBubble, IfIdFlush, PcWr} !== 3'b011) begin failures++; $display("FAIL slow_mem_release got=%b exp=011", {MemWbBubble, IfIdFlush, PcWr}); end
      end
      advance();
    end
    clearIn();
    settle();
    checks++; if (frozen != 4 || StallCnt !== 16'd4) begin failures++; $display("FAIL slow_mem_count got frozen=%0d cnt=%0d exp 4/4", frozen, StallCnt); end
    advance();
  endtask

  task automatic test_timeout();
    int frozen = 0;
    pulseRst(1);
    MEM_DmReq = 1;
    for (int i = 0; i < TO; i++) begin
      settle();
      checks++; if (obsAll !== expAll()) begin failures++; $display("FAIL timeout_model c%0d got=%h exp=%h", i, obsAll, expAll()); end
      if (PcWr === 1'b0) frozen++;
      if (i == TO - 1) begin
        checks++; if ({PcWr, MemWbBubble, DmErr} !== 3'b110) begin failures++; $display("FAIL timeout_abort got=%b exp=110", {PcWr, MemWbBubble, DmErr}); end
      end
      advance();
    end
    MEM_DmReq = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (obsAll !== expAll()) begin failures++; $display("FAIL timeout_after_model got=%h exp=%h", obsAll, expAll()); end
      advance();
    end
    checks++; if (frozen != TO - 1 || DmErr !== 1'b1 || PcWr !== 1'b1) begin failures++; $display("FAIL timeout_summary got frozen=%0d err=%b exp %0d/1", frozen, DmErr, TO - 1); end
  endtask

  task automatic test_reset();
    clearIn();
    MEM_DmReq = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++; if (obsAll !== expAll()) begin failures++; $display("FAIL reset_pre_model got=%h exp=%h", obsAll, expAll()); end
      advance();
    end
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (obsCtl !== 7'b0010101) begin failures++; $display("FAIL reset_forced got=%b exp=0010101", obsCtl); end
      advance();
    end
    rst = 0; clearIn();
    settle();
    checks++; if ({obsCtl, DmErr, StallCnt} !== {7'b1101010, 1'b0, 16'd0}) begin failures++; $display("FAIL reset_after got=%b/%b/%0d exp=1101010/0/0", obsCtl, DmErr, StallCnt); end
    checks++; if (obsAll !== expAll()) begin failures++; $display("FAIL reset_after_model got=%h exp=%h", obsAll, expAll()); end
    advance();
  endtask

  task automatic test_saturation();
    pulseRst(1);
    EX_MemRead = 1; EX_RfWr = 1; EX_Rw = 3; ID_Rs = 3; ID_UsesRs = 1;
    for (int i = 0; i < 20; i++) begin
      settle();
      checks++; if (obsAll !== expAll()) begin failures++; $display("FAIL saturation_model c%0d got=%h exp=%h", i, obsAll, expAll()); end
      advance();
    end
    clearIn();
    settle();
    checks++; if (sStallCnt !== 4'd15 || StallCnt !== 16'd20) begin failures++; $display("FAIL saturation got=%0d/%0d exp=15/20", sStallCnt, StallCnt); end
    advance();
  endtask

  task automatic test_back_to_back();
    bit [1:0] seq [7] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11, 2'b00};
    pulseRst(1);
    for (int i = 0; i < 7; i++) begin
      MEM_DmReq = seq[i][1]; DmReady = seq[i][0];
      settle();
      checks++; if (obsAll !== expAll()) begin failures++; $display("FAIL back_to_back_model c%0d got=%h exp=%h", i, obsAll, expAll()); end
      advance();
    end
    settle();
    checks++; if (StallCnt !== 16'd3) begin failures++; $display("FAIL back_to_back_cnt got=%0d exp=3", StallCnt); end
    advance();
  endtask

  task automatic test_random();
    bit slow = 0;
    pulseRst(1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) slow = ~slow;
      rst = ($urandom_range(0, 63) == 0);
      ID_Rs = 5'($urandom_range(0, 3)); ID_Rt = 5'($urandom_range(0, 3)); EX_Rw = 5'($urandom_range(0, 3));
      ID_UsesRs = 1'($urandom); ID_UsesRt = 1'($urandom);
      EX_MemRead = 1'($urandom); EX_RfWr = 1'($urandom);
      EX_BranchTaken = ($urandom_range(0, 5) == 0);
      MEM_DmReq = ($urandom_range(0, 3) == 0);
      DmReady = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
      settle();
      checks++; if (obsAll !== expAll()) begin failures++; $display("FAIL random_model c%0d got=%h exp=%h", i, obsAll, expAll()); end
      advance();
    end
    rst = 0;
  endtask

  initial begin
    clearIn();
    rst = 1;
    pulseRst(2);
    test_loaduse();
    test_branch_loaduse();
    test_slow_mem();
    test_timeout();
    test_reset();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
